cpu_clk_ctrl: RTL and testbench

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_ctrl.sv | 138 +++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: full speed, divided run, or debounced single-step.
// Outputs are registered and change one clk after the inputs that cause them.
// No backpressure; build with CPU_CLK_CTRL_CYCLE_CNT_EN to get a live cycle_cnt.
module cpu_clk_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DIV_MAX    = 25000000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_div_en,
    input  logic             run_sw,
    input  logic             step_btn,
    output logic             cpu_ce,
    output logic             clk_sig,
    output logic [WIDTH-1:0] cycle_cnt
);

    localparam int DIVW = $clog2(DIV_MAX);
    localparam int DEBW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV_MAX - 1);
    localparam logic [DEBW-1:0] DEB_LAST = DEBW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        FAST      = 2'd0,
        RUN       = 2'd1,
        STEP_IDLE = 2'd2,
        STEP_HELD = 2'd3
    } state_t;

    state_t            state;
    state_t            nxt_state;
    logic [1:0]        sync;
    logic              btn_s;
    logic              deb;
    logic [DEBW-1:0]   deb_cnt;
    logic [DIVW-1:0]   div_q;
    logic [DIVW-1:0]   div_nxt;
    logic              ce_nxt;

    assign btn_s = sync[1];

    // Two-flop synchronizer for the asynchronous push-button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], step_btn};
        end
    end

    // Debounce: accept the new level only after DEB_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s != deb) begin
            if (deb_cnt == DEB_LAST) begin
                deb     <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEBW'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    // State, divider and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FAST;
            div_q   <= '0;
            cpu_ce  <= 1'b0;
            clk_sig <= 1'b0;
        end else begin
            state   <= nxt_state;
            div_q   <= div_nxt;
            cpu_ce  <= ce_nxt;
            clk_sig <= clk_sig ^ ce_nxt;
        end
    end

    // Mode selection is driven purely by the switches and debounced level, so a
    // mode change always wins over any pulse the old mode would have issued.
    always_comb begin
        nxt_state = FAST;
        div_nxt   = '0;
        ce_nxt    = 1'b0;
        if (!clk_div_en) begin
            nxt_state = FAST;
        end else if (run_sw) begin
            nxt_state = RUN;
        end else begin
            nxt_state = deb ? STEP_HELD : STEP_IDLE;
        end

        case (nxt_state)
            FAST: begin
                ce_nxt = 1'b1;
            end
            RUN: begin
                // Counter restarts on entry so the first pulse lands DIV_MAX clks later.
                if (state != RUN || div_q == DIV_LAST) begin
                    div_nxt = '0;
                end else begin
                    div_nxt = div_q + DIVW'(1);
                end
                ce_nxt = (div_nxt == DIV_LAST);
            end
            STEP_HELD: begin
                // Only the idle->held edge pulses; entering held from another mode does not.
                ce_nxt = (state == STEP_IDLE);
            end
            default: begin
                ce_nxt = 1'b0;
            end
        endcase
    end

`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
    logic [WIDTH-1:0] cnt_q;

    // Counts pulses as they are issued, so it already includes the one on cpu_ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ce_nxt) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with a per-cycle expectation queue.
// Expectations are pushed as each cycle's stimulus is driven, popped after the edge.
// No backpressure; clock free-runs so every wait is a fixed number of edges.
module tb_cpu_clk_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             clk_div_en;
    logic             run_sw;
    logic             step_btn;
    logic             cpu_ce;
    logic             clk_sig;
    logic [WIDTH-1:0] cycle_cnt;

    typedef struct packed {
        logic             ce;
        logic             sig;
        logic [WIDTH-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    logic             exp_sig;
    logic [WIDTH-1:0] exp_cnt;
    logic [WIDTH-1:0] base_cnt;
    int               vectors;
    int               fails;

    cpu_clk_ctrl #(
        .WIDTH      (WIDTH),
        .DIV_MAX    (4),
        .DEB_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_div_en (clk_div_en),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .cpu_ce     (cpu_ce),
        .clk_sig    (clk_sig),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Record what the next clk edge must produce; a pulse toggles clk_sig and bumps the count.
    task automatic expect_cyc(input logic ce);
        if (ce) begin
            exp_sig = ~exp_sig;
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
            exp_cnt = exp_cnt + WIDTH'(1);
`endif
        end
        sb.push_back('{ce: ce, sig: exp_sig, cnt: exp_cnt});
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            vectors++;
            fails++;
            $display("FAIL %s: observed empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ce"},  WIDTH'(cpu_ce),  WIDTH'(e.ce));
            chk({tag, "_sig"}, WIDTH'(clk_sig), WIDTH'(e.sig));
            chk({tag, "_cnt"}, cycle_cnt,       e.cnt);
        end
    endtask

    task automatic cyc(input logic btn, input logic ce, input string tag);
        step_btn = btn;
        expect_cyc(ce);
        tick(tag);
    endtask

    initial begin
        vectors    = 0;
        fails      = 0;
        exp_sig    = 1'b0;
        exp_cnt    = '0;
        base_cnt   = '0;
        rst_n      = 1'b0;
        clk_div_en = 1'b0;
        run_sw     = 1'b0;
        step_btn   = 1'b0;

        // Reset state before and across a clock edge.
        #3;
        chk("rst_ce",  WIDTH'(cpu_ce),  '0);
        chk("rst_sig", WIDTH'(clk_sig), '0);
        chk("rst_cnt", cycle_cnt,       '0);
        @(posedge clk);
        #1;
        chk("rst_hold_ce", WIDTH'(cpu_ce), '0);
        rst_n = 1'b1;

        // Full speed: a pulse on every clk, starting with the first edge.
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, "fast");
        chk("fast_cnt10", cycle_cnt, exp_cnt);

        // Divided run: pulses on the 4th, 8th, 12th and 16th edge after entry.
        clk_div_en = 1'b1;
        run_sw     = 1'b1;
        for (int i = 0; i < 16; i++) cyc(1'b0, (i % 4) == 3, "run");

        // Single-step with short glitches that must be rejected.
        run_sw = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, "step_idle");
        cyc(1'b1, 1'b0, "glitch1");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, "glitch1_gap");
        cyc(1'b1, 1'b0, "glitch2");
        cyc(1'b1, 1'b0, "glitch2");
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, "glitch2_gap");

        // Held press: 2 sync + 3 debounce edges, pulse on the edge after that, then nothing.
        for (int i = 0; i < 20; i++) cyc(1'b1, i == 5, "press1");
        base_cnt = exp_cnt;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, "release1");
        for (int i = 0; i < 20; i++) cyc(1'b1, i == 5, "press2");
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, "release2");
        for (int i = 0; i < 20; i++) cyc(1'b1, i == 5, "press3");
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
        chk("two_press_cnt", cycle_cnt, base_cnt + WIDTH'(2));
`else
        chk("two_press_cnt", cycle_cnt, '0);
`endif

        // Switch to run on the very edge a step pulse was due: pulse dropped.
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, "release3");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, "press4");
        run_sw = 1'b1;
        cyc(1'b1, 1'b0, "mode_prio");
        cyc(1'b1, 1'b0, "run_div1");
        cyc(1'b1, 1'b0, "run_div2");

        // Asynchronous reset mid-divide.
        #1;
        rst_n      = 1'b0;
        clk_div_en = 1'b0;
        run_sw     = 1'b0;
        #1;
        chk("arst_ce",  WIDTH'(cpu_ce),  '0);
        chk("arst_sig", WIDTH'(clk_sig), '0);
        chk("arst_cnt", cycle_cnt,       '0);
        exp_sig = 1'b0;
        exp_cnt = '0;
        @(posedge clk);
        #1;
        chk("arst_hold_ce", WIDTH'(cpu_ce), '0);
        rst_n = 1'b1;

        // Fresh full-speed run from reset up to and across the counter wrap.
        for (int i = 0; i < 255; i++) cyc(1'b1, 1'b1, "fast255");
`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
        chk("cnt_255", cycle_cnt, 8'd255);
`else
        chk("cnt_255", cycle_cnt, '0);
`endif
        cyc(1'b1, 1'b1, "wrap");
        chk("cnt_wrap", cycle_cnt, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
